// File: rtl/led_scan_scheduler_if.sv
// Bundle between control logic and the display scan scheduler: nibble writes,
// commit and scroll controls in; anode/character/decimal-point drive and status out.
interface led_scan_scheduler_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       scroll_en;
    logic       commit_pending;
    logic       frame_tick;
    logic       an3;
    logic       an2;
    logic       an1;
    logic       an0;
    logic [3:0] char;
    logic       dp;

    modport master (
        output wr_en, wr_addr, wr_data, commit, scroll_en,
        input  commit_pending, frame_tick, an3, an2, an1, an0, char, dp
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, scroll_en,
        output commit_pending, frame_tick, an3, an2, an1, an0, char, dp
    );
endinterface

// File: rtl/led_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: double-buffered 16-nibble message,
// blanked anode rotation an3..an0, frame-boundary commit and optional scrolling.
module led_scan_scheduler #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLANK         = 2000,
    parameter int unsigned SCROLL_FRAMES = 64
) (
    input logic                 clk,
    input logic                 reset,
    led_scan_scheduler_if.slave bus
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FcW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [3:0]      shadow_q [16];
    logic [3:0]      shadow_d [16];
    logic [3:0]      active_q [16];
    logic [3:0]      active_d [16];
    logic [3:0]      offset_q, offset_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      slot_q, slot_d;
    logic [FcW-1:0]  fcnt_q, fcnt_d;
    logic            pend_q, pend_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      char_q, char_d;
    logic            dp_q, dp_d;
    logic            ftick_q, ftick_d;

    logic            slot_last;
    logic            frame_end;
    logic            do_copy;
    logic            lit_d;
    logic [3:0]      idx_d;

    always_comb begin
        slot_last = (cnt_q == CntW'(SCAN_DIV - 1));
        frame_end = slot_last && (slot_q == 2'd3);
        do_copy   = frame_end && (pend_q || bus.commit);

        cnt_d  = slot_last ? '0 : cnt_q + 1'b1;
        slot_d = slot_last ? slot_q + 2'd1 : slot_q;

        shadow_d = shadow_q;
        if (bus.wr_en) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
        end

        // Copy takes the pre-write shadow and outranks any scroll step.
        active_d = do_copy ? shadow_q : active_q;
        offset_d = offset_q;
        fcnt_d   = fcnt_q;
        pend_d   = pend_q;
        if (do_copy) begin
            offset_d = 4'd0;
            fcnt_d   = '0;
            pend_d   = 1'b0;
        end else begin
            if (bus.commit) begin
                pend_d = 1'b1;
            end
            if (frame_end && bus.scroll_en) begin
                if (fcnt_q == FcW'(SCROLL_FRAMES - 1)) begin
                    fcnt_d   = '0;
                    offset_d = offset_q + 4'd1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        // Outputs are computed for the cycle the state is about to enter.
        idx_d   = offset_d + {2'b00, slot_d};
        lit_d   = (cnt_d >= CntW'(BLANK));
        an_d    = lit_d ? ~(4'b1000 >> slot_d) : 4'hF;
        char_d  = active_d[idx_d];
        dp_d    = !(lit_d && bus.scroll_en && (idx_d == 4'd0));
        ftick_d = (slot_d == 2'd3) && (cnt_d == CntW'(SCAN_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '{default: 4'h0};
            active_q <= '{default: 4'h0};
            offset_q <= 4'd0;
            cnt_q    <= '0;
            slot_q   <= 2'd0;
            fcnt_q   <= '0;
            pend_q   <= 1'b0;
            an_q     <= 4'hF;
            char_q   <= 4'h0;
            dp_q     <= 1'b1;
            ftick_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            fcnt_q   <= fcnt_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            char_q   <= char_d;
            dp_q     <= dp_d;
            ftick_q  <= ftick_d;
        end
    end

    assign bus.an3            = an_q[3];
    assign bus.an2            = an_q[2];
    assign bus.an1            = an_q[1];
    assign bus.an0            = an_q[0];
    assign bus.char           = char_q;
    assign bus.dp             = dp_q;
    assign bus.commit_pending = pend_q;
    assign bus.frame_tick     = ftick_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Bench for led_scan_scheduler: directed vector table, scroll/commit corner
// sequences and randomized traffic checked against a cycle-indexed reference model.
module tb_led_scan_scheduler;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int SF = 2;
    localparam int FR = 4 * SD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_scan_scheduler_if bus ();

    led_scan_scheduler #(
        .SCAN_DIV      (SD),
        .BLANK         (BL),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle index since reset plus message state.
    logic [3:0] m_shadow [16];
    logic [3:0] m_active [16];
    int         m_off, m_fc, m_t;
    bit         m_pend, m_sprev;

    typedef struct {
        bit         rst;
        bit         we;
        logic [3:0] wa;
        logic [3:0] wd;
        bit         cm;
        int         until_t;
        logic [3:0] an;
        logic [3:0] ch;
        bit         dp;
        bit         pend;
        bit         ft;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] dut_out();
        return {bus.an3, bus.an2, bus.an1, bus.an0, bus.char, bus.dp,
                bus.commit_pending, bus.frame_tick};
    endfunction

    function automatic logic [10:0] model_out();
        int         slot, rel, idx;
        bit         lit;
        logic [3:0] an;
        bit         dp, ft;
        slot = (m_t / SD) % 4;
        rel  = m_t % SD;
        idx  = (m_off + slot) % 16;
        lit  = (rel >= BL);
        an   = 4'hF;
        if (lit) an[3 - slot] = 1'b0;
        dp   = !(lit && m_sprev && idx == 0);
        ft   = ((m_t % FR) == FR - 1);
        return {an, m_active[idx], dp, m_pend, ft};
    endfunction

    task automatic model_adv();
        logic [3:0] old_sh [16];
        bit         fend;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[i] = 4'h0;
                m_active[i] = 4'h0;
            end
            m_off = 0; m_fc = 0; m_t = 0; m_pend = 0; m_sprev = 0;
        end else begin
            fend   = ((m_t % FR) == FR - 1);
            old_sh = m_shadow;
            if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
            if (fend && (m_pend || bus.commit)) begin
                m_active = old_sh;
                m_off    = 0;
                m_fc     = 0;
                m_pend   = 0;
            end else begin
                if (bus.commit) m_pend = 1;
                if (fend && bus.scroll_en) begin
                    m_fc++;
                    if (m_fc == SF) begin
                        m_fc  = 0;
                        m_off = (m_off + 1) % 16;
                    end
                end
            end
            m_sprev = bus.scroll_en;
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got an/char/dp/pend/tick=%h required %h",
                     name, m_t, got, exp);
        end
    endtask

    task automatic step();
        model_adv();
        @(posedge clk);
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic run_to(input int t);
        while (m_t < t) step();
    endtask

    task automatic expect_at(input string name, input int t, input logic [3:0] an,
                             input logic [3:0] ch, input bit dp);
        run_to(t);
        check(name, dut_out(), {an, ch, dp, 1'b0, 1'b0});
    endtask

    task automatic add(input bit rst, input bit we, input logic [3:0] wa, input logic [3:0] wd,
                       input bit cm, input int until_t, input logic [3:0] an,
                       input logic [3:0] ch, input bit dp, input bit pend, input bit ft);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.until_t = until_t;
        v.an = an; v.ch = ch; v.dp = dp; v.pend = pend; v.ft = ft;
        vecs.push_back(v);
    endtask

    int s;

    initial begin
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 4'h0;
        bus.wr_data   = 4'h0;
        bus.commit    = 1'b0;
        bus.scroll_en = 1'b0;
        m_t           = 0;
        repeat (3) step();

        //  rst we wa    wd    cm until an     ch    dp pend ft
        add(1, 0, 4'h0, 4'h0, 0,   0, 4'hF, 4'h0, 1, 0, 0);
        add(0, 1, 4'h0, 4'h1, 0,   2, 4'h7, 4'h0, 1, 0, 0);
        add(0, 1, 4'h1, 4'h2, 0,   3, 4'h7, 4'h0, 1, 0, 0);
        add(0, 1, 4'h2, 4'h3, 0,   4, 4'h7, 4'h0, 1, 0, 0);
        add(0, 1, 4'h3, 4'h4, 0,   5, 4'h7, 4'h0, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 1,   6, 4'h7, 4'h0, 1, 1, 0);
        add(0, 0, 4'h0, 4'h0, 0,  31, 4'hE, 4'h0, 1, 1, 1);
        add(0, 0, 4'h0, 4'h0, 0,  32, 4'hF, 4'h1, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0,  34, 4'h7, 4'h1, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0,  42, 4'hB, 4'h2, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0,  50, 4'hD, 4'h3, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0,  58, 4'hE, 4'h4, 1, 0, 0);
        add(0, 1, 4'h0, 4'hF, 0,  66, 4'h7, 4'h1, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0, 194, 4'h7, 4'h1, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0, 204, 4'hB, 4'h2, 1, 0, 0);
        add(1, 0, 4'h0, 4'h0, 0,   0, 4'hF, 4'h0, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0,  34, 4'h7, 4'h0, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 1,  35, 4'h7, 4'h0, 1, 1, 0);
        add(0, 0, 4'h0, 4'h0, 0,  66, 4'h7, 4'h0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            bus.wr_en   = vecs[i].we;
            bus.wr_addr = vecs[i].wa;
            bus.wr_data = vecs[i].wd;
            bus.commit  = vecs[i].cm;
            step();
            reset      = 1'b0;
            bus.wr_en  = 1'b0;
            bus.commit = 1'b0;
            run_to(vecs[i].until_t);
            check($sformatf("vec%0d", i), dut_out(),
                  {vecs[i].an, vecs[i].ch, vecs[i].dp, vecs[i].pend, vecs[i].ft});
        end

        // Scroll wrap: message 0..F, scrolling starts on a frame boundary.
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = 4'(i);
            step();
        end
        bus.wr_en  = 1'b0;
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        s = ((m_t / FR) + 1) * FR;
        run_to(s);
        bus.scroll_en = 1'b1;
        expect_at("scroll_an3", s + FR * 28 + 2,  4'h7, 4'hE, 1'b1);
        expect_at("scroll_an2", s + FR * 28 + 10, 4'hB, 4'hF, 1'b1);
        expect_at("scroll_an1", s + FR * 28 + 18, 4'hD, 4'h0, 1'b0);
        expect_at("scroll_an0", s + FR * 28 + 26, 4'hE, 4'h1, 1'b1);
        expect_at("scroll_f",   s + FR * 30 + 2,  4'h7, 4'hF, 1'b1);

        // Commit lands on the same frame end as a scroll step.
        run_to(s + FR * 34 - 1);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        expect_at("collide_0", s + FR * 34 + 2, 4'h7, 4'h0, 1'b0);
        expect_at("collide_1", s + FR * 35 + 2, 4'h7, 4'h0, 1'b0);
        expect_at("collide_2", s + FR * 36 + 2, 4'h7, 4'h1, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 599) == 0);
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_addr = 4'($urandom_range(0, 15));
            bus.wr_data = 4'($urandom_range(0, 15));
            bus.commit  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) bus.scroll_en = ~bus.scroll_en;
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
